// File: rtl/rf_clkgen_pkg.sv
// Shared types and constants for the NCO clock generator.
// ftw_to_freq is for benches and reference models only.
package rf_clkgen_pkg;

    localparam int ACC_W_DEFAULT = 32;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } clkgen_state_t;

    // Output frequency of a channel for a given reference frequency.
    function automatic real ftw_to_freq(input real f_ref, input longint unsigned ftw,
                                        input int acc_w);
        return f_ref * real'(ftw) / (2.0 ** acc_w);
    endfunction

endpackage

// File: rtl/rf_nco_channel.sv
// One NCO channel: phase accumulator, tuning word, stored phase and wrap strobe.
// A load takes priority over the add and suppresses the strobe for that edge.
module rf_nco_channel
    import rf_clkgen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load_cfg,
    input  logic             load_sync,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [ACC_W-1:0] cfg_phase,
    output logic             outclk,
    output logic             outstb
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw;
    logic [ACC_W-1:0] phase;
    logic [ACC_W:0]   sum;

    assign sum    = {1'b0, acc} + {1'b0, ftw};
    assign outclk = acc[ACC_W-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            ftw    <= '0;
            phase  <= '0;
            outstb <= 1'b0;
        end else if (load_cfg) begin
            ftw    <= cfg_ftw;
            phase  <= cfg_phase;
            acc    <= cfg_phase;
            outstb <= 1'b0;
        end else if (load_sync) begin
            acc    <= phase;
            outstb <= 1'b0;
        end else begin
            // ftw == 0 leaves acc unchanged and can never carry
            acc    <= sum[ACC_W-1:0];
            outstb <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/rf_nco_clkgen.sv
// Multi-channel NCO clock generator with settle/lock sequencing and run-time config.
//   state  | meaning
//   SETTLE | outputs may be transitioning; cnt counts up to SETTLE_CYCLES-1, cfg held off
//   LOCKED | outputs stable; one cfg request accepted, which restarts SETTLE
module rf_nco_clkgen
    import rf_clkgen_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int ACC_W         = ACC_W_DEFAULT,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]          cfg_ftw,
    input  logic [ACC_W-1:0]          cfg_phase,
    input  logic                      cfg_sync,
    output logic [NUM_CH-1:0]         outclk,
    output logic [NUM_CH-1:0]         outstb,
    output logic                      locked
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    clkgen_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign cfg_ready = (state == LOCKED);
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state  <= SETTLE;
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (cfg_valid) begin
                        state  <= SETTLE;
                        cnt    <= '0;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SETTLE;
                    cnt    <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range cfg_ch matches no channel but still syncs and re-settles.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        rf_nco_channel #(
            .ACC_W(ACC_W)
        ) u_ch (
            .refclk    (refclk),
            .rst       (rst),
            .load_cfg  (accept && (cfg_ch == IDX)),
            .load_sync (accept && cfg_sync),
            .cfg_ftw   (cfg_ftw),
            .cfg_phase (cfg_phase),
            .outclk    (outclk[i]),
            .outstb    (outstb[i])
        );
    end

endmodule

// File: doc/rf_nco_clkgen.md
# rf_nco_clkgen

Parametrised multi-channel clock generator for the RF timing chain. From the single reference clock, it derives NUM_CH independent output clocks and one-cycle strobes using phase-accumulator (NCO) dividers. Frequency and phase are programmable at run time, and a sync mode aligns all channels in phase. It sits downstream of the board PLL and exposes the same refclk/rst/locked contract, so consumers gate on locked exactly as they do on the PLL.

## Interface

Parameters:
- NUM_CH, 4: number of output channels; must be at least 2.
- ACC_W, 32: accumulator, tuning-word and phase width.
- SETTLE_CYCLES, 16: cycles that locked stays low after reset release or after any reconfiguration; must be at least 1.

Ports (clock and reset first):
- refclk  in  1: sole clock; all logic is on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- cfg_valid  in  1: configuration request.
- cfg_ready  out  1: configuration can be accepted.
- cfg_ch  in  $clog2(NUM_CH): target channel.
- cfg_ftw  in  ACC_W: frequency tuning word.
- cfg_phase  in  ACC_W: phase offset loaded into the accumulator.
- cfg_sync  in  1: reload every channel's accumulator from its stored phase.
- outclk  out  NUM_CH: generated clocks, equal to the accumulator MSB.
- outstb  out  NUM_CH: one-cycle pulse per accumulator wrap.
- locked  out  1: outputs are stable and configured.

## Operation

- Per channel, registers acc, ftw and phase. While ftw is non-zero, acc advances by ftw each cycle, modulo 2^ACC_W.
- Output frequency is f_refclk × ftw / 2^ACC_W. The tuning word must satisfy ftw ≤ 2^(ACC_W-1).
- outclk[i] equals acc[i][ACC_W-1], taken directly from the register.
- outstb[i] is registered. It is 1 in the cycle after an add that carries out of bit ACC_W-1.
- If ftw[i] = 0, acc[i] holds its value, outclk[i] is constant and outstb[i] stays 0.
- Control FSM, defined in the package, has two states: SETTLE and LOCKED.
  - Reset puts the FSM in SETTLE with the counter cnt = 0.
  - In SETTLE, cnt increments each cycle. When cnt reaches SETTLE_CYCLES-1, the next state is LOCKED.
  - In LOCKED, an accepted configuration moves the FSM to SETTLE with cnt = 0.
- cfg_ready = (state == LOCKED). locked is registered and equals (state == LOCKED).
- A configuration is accepted when cfg_valid && cfg_ready. At that edge:
  - The target channel loads ftw ← cfg_ftw, phase ← cfg_phase and acc ← cfg_phase.
  - If cfg_sync = 1, every other channel loads acc ← its stored phase at the same edge.
- No outstb pulse is generated on any edge where acc is loaded rather than added.
- cnt width is $clog2(SETTLE_CYCLES+1).
- cfg_ch ≥ NUM_CH is accepted but writes no channel. cfg_sync still takes effect, and the FSM still re-settles.

## Timing

- Reset values: acc = 0, ftw = 0, phase = 0, outclk = 0, outstb = 0, locked = 0, cfg_ready = 0.
- Reset acts immediately on assertion, without a clock edge.
- After reset release, locked and cfg_ready rise after the SETTLE_CYCLES-th rising edge.
- A configuration accepted at edge T:
  - The new acc is visible after T.
  - The first add happens at edge T+1.
  - locked is 0 from T through T+SETTLE_CYCLES-1 and returns to 1 after edge T+SETTLE_CYCLES.
- Channels keep running while in SETTLE. The low locked flag only signals that the outputs may be transitioning.
- cfg_valid asserted while cfg_ready = 0 is held off. cfg_* must stay stable until accepted.
- At most one configuration is accepted per SETTLE period.
- A reset asserted mid-SETTLE restarts the full settle sequence with all channels cleared.

## Structure

- Package rf_clkgen_pkg holds:
  - the FSM state enum (SETTLE, LOCKED);
  - the default ACC_W constant;
  - a helper function converting ftw to a frequency, for use in benches.
- Sub-module rf_nco_channel contains one channel's acc, ftw and phase registers, the add/load mux and the strobe register. The top level instantiates it NUM_CH times and owns the FSM and cfg decode.

## Test plan

All scenarios use NUM_CH = 4, ACC_W = 32, SETTLE_CYCLES = 16.

- Reset release: locked and cfg_ready stay 0 for 15 edges and read 1 after edge 16. outclk = 0000 and no strobes throughout.
- ch0, ftw = 0x4000_0000, phase = 0: outclk[0] has a period of 4 cycles (2 high, 2 low), outstb[0] pulses once every 4 cycles, and locked is low for exactly 16 cycles after acceptance.
- Anti-phase alignment:
  - Configure ch1 with ftw = 0x4000_0000 and phase = 0x8000_0000.
  - Then configure ch0 with cfg_sync = 1.
  - Required: outclk[1] == ~outclk[0] on every cycle, and the strobes are 2 cycles apart.
- Back-pressure: cfg_valid held high through SETTLE gives no acceptance until cfg_ready = 1. Exactly one acceptance follows.
- ftw = 0 on a running ch2 with phase = 0x8000_0000: outclk[2] holds at 1 and outstb[2] stays 0 indefinitely.
- rst asserted 5 cycles into SETTLE with channels running: all outputs go to 0 without a clock edge, and locked rises 16 edges after rst is released.
